sys_pio_gpio: RTL
=================

Name: sys_pio_gpio

Overview:
- Parametrised Avalon-MM GPIO block; successor to the fixed 32-bit output-only PIO.
- Per-bit direction control, atomic set/clear writes, synchronised input sampling, edge capture and a maskable level interrupt.
- Sits on the sys interconnect as an MM slave and drives board pins through external tristate buffers using out_port/oe_port.

Parameters:
- DATA_WIDTH, 32, pin count and Avalon data width (1..32).
- OUT_RESET, 0, reset value of the output data register.
- DIR_RESET, 0, reset value of the direction register; bit=1 means output.
- SYNC_STAGES, 2, input synchroniser depth (>=2).
- EDGE_TYPE, 0, edge-capture mode: 0 rising, 1 falling, 2 any.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  3  word register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- read_n  in  1  active-low read strobe
- writedata  in  DATA_WIDTH  write data
- readdata  out  DATA_WIDTH  registered read data
- in_port  in  DATA_WIDTH  asynchronous pin inputs
- out_port  out  DATA_WIDTH  output data register
- oe_port  out  DATA_WIDTH  per-bit output enable (= direction register)
- irq  out  1  level interrupt, registered

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk.
  - out_port=OUT_RESET, oe_port=DIR_RESET.
  - readdata=0, irq=0.
  - Synchroniser, delay register, edge_capture and irq_mask all 0.
- Register map (word addresses):
  - 0 DATA: write loads the output register; read returns (out & dir) | (in_sync & ~dir).
  - 1 DIRECTION: read/write.
  - 2 IRQ_MASK: read/write.
  - 3 EDGE_CAPTURE: read; write-1-to-clear per bit.
  - 4 OUTSET: write ORs writedata into the output register; reads 0.
  - 5 OUTCLEAR: write clears bits set in writedata; reads 0.
  - 6, 7: reserved; writes ignored, reads 0.
- Writes: take effect on the clk edge where chipselect=1 and write_n=0. New out_port/oe_port values are visible the following cycle.
- Reads: fixed read latency 1.
  - readdata is registered on the edge where chipselect=1 and read_n=0.
  - It holds its value otherwise.
  - Simultaneous read and write to the same address returns the pre-write value.
- Input path:
  - in_port passes through a SYNC_STAGES flip-flop chain to in_sync, then one delay register to in_prev.
  - Pin-to-DATA-read latency: SYNC_STAGES cycles plus 1 read cycle.
- Edge detect, per bit:
  - rise = in_sync & ~in_prev
  - fall = ~in_sync & in_prev
  - EDGE_TYPE selects rise, fall, or rise|fall.
  - Detection is gated by ~dir: output-direction bits never capture.
- edge_capture update each cycle: ec <= (ec & ~clear_mask) | edge.
  - clear_mask = writedata when writing address 3, else 0.
  - An edge in the same cycle as its clear leaves the bit set (set wins).
- irq <= |(edge_capture & irq_mask), registered.
  - irq deasserts 1 cycle after the last pending masked bit is cleared.
  - Unmasking an already captured bit raises irq the cycle after the mask write.
- Direction change:
  - Switching a bit to output does not clear its edge_capture bit.
  - Its in_sync/in_prev keep tracking the pin.
- Writes to address 0, 4 and 5 affect all bits regardless of direction; out_port drives regardless, and the external buffer uses oe_port.
- Reset mid-operation: all state returns to reset values immediately and asynchronously. No pending capture survives.

Decomposition:
- Shared package sys_pio_pkg holds:
  - Register address constants: ADDR_DATA=0, ADDR_DIR=1, ADDR_MASK=2, ADDR_EDGE=3, ADDR_SET=4, ADDR_CLR=5.
  - EDGE_TYPE encodings: EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2.
- One sub-module, sys_pio_sync: parametrised SYNC_STAGES-deep multibit synchroniser with asynchronous reset to 0. Reused by future input blocks.

Test Plan:
- Reset check: OUT_RESET=0xA5, DIR_RESET=0x0F, DATA_WIDTH=8. Release reset -> out_port=0xA5, oe_port=0x0F, irq=0. Read address 1 -> readdata=0x0F one cycle after strobe.
- Set/clear: write DATA=0x00F0, then OUTSET=0x0003, then OUTCLEAR=0x0010 -> out_port sequence 0x00F0, 0x00F3, 0x00E3, each one cycle after its write. Read of address 4 returns 0.
- Mixed read: DIR=0x0000FFFF, out=0x1234, in_port=0xABCD0000 held -> after SYNC_STAGES+1 cycles, DATA read returns 0xABCD1234.
- Rising capture with IRQ: EDGE_TYPE=0, DIR=0, MASK=0x1.
  - in_port[0] 0->1 -> edge_capture[0]=1 and irq=1 within SYNC_STAGES+2 cycles.
  - in_port[0] 1->0 produces no new capture.
  - Write 0x1 to address 3 -> irq=0 the following cycle.
- Set-wins collision: EDGE_TYPE=2; time a toggle on in_sync[3] coincident with a write-1-clear of bit 3 -> edge_capture[3] remains 1.
- Output-direction masking: DIR=0xFFFFFFFF, MASK=all ones; toggle all in_port bits -> edge_capture stays 0 and irq stays 0.

Source files
------------

// File: rtl/sys_pio_pkg.sv
// Shared definitions for the sys PIO family: register word addresses and
// edge-capture mode encodings.
package sys_pio_pkg;

  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_DIR  = 3'd1;
  localparam logic [2:0] ADDR_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE = 3'd3;
  localparam logic [2:0] ADDR_SET  = 3'd4;
  localparam logic [2:0] ADDR_CLR  = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/sys_pio_sync.sv
// Multibit flip-flop chain synchroniser for asynchronous inputs; every bit is
// treated independently, so only use it on signals without cross-bit coherency.
module sys_pio_sync #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain <= '{default: '0};
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/sys_pio_gpio.sv
// Avalon-MM GPIO: per-bit direction, atomic set/clear, synchronised inputs,
// per-bit edge capture and a maskable registered level interrupt.
module sys_pio_gpio
  import sys_pio_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] OUT_RESET   = '0,
  parameter logic [DATA_WIDTH-1:0] DIR_RESET   = '0,
  parameter int                    SYNC_STAGES = 2,
  parameter int                    EDGE_TYPE   = EDGE_RISE
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic                  read_n,
  input  logic [DATA_WIDTH-1:0] writedata,
  output logic [DATA_WIDTH-1:0] readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic [DATA_WIDTH-1:0] oe_port,
  output logic                  irq
);

  // Bus protocol: Avalon-MM slave with no wait states. A write is accepted on
  // every edge with chipselect & ~write_n; a read strobe (chipselect & ~read_n)
  // loads readdata on that edge, giving a fixed read latency of one cycle.
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] in_sync;
  logic [DATA_WIDTH-1:0] in_prev;
  logic [DATA_WIDTH-1:0] irq_mask;
  logic [DATA_WIDTH-1:0] edge_capture;
  logic [DATA_WIDTH-1:0] edge_hit;
  logic [DATA_WIDTH-1:0] clear_mask;
  logic [DATA_WIDTH-1:0] rd_mux;

  assign wr_en = chipselect & ~write_n;
  assign rd_en = chipselect & ~read_n;

  sys_pio_sync #(
    .WIDTH  (DATA_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (in_port),
    .q       (in_sync)
  );

  // Output-direction bits are excluded so driven pins never raise captures.
  always_comb begin
    edge_hit = '0;
    case (EDGE_TYPE)
      EDGE_RISE: edge_hit = in_sync & ~in_prev;
      EDGE_FALL: edge_hit = ~in_sync & in_prev;
      default:   edge_hit = in_sync ^ in_prev;
    endcase
    edge_hit = edge_hit & ~oe_port;
  end

  assign clear_mask = (wr_en && address == ADDR_EDGE) ? writedata : '0;

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA: rd_mux = (out_port & oe_port) | (in_sync & ~oe_port);
      ADDR_DIR:  rd_mux = oe_port;
      ADDR_MASK: rd_mux = irq_mask;
      ADDR_EDGE: rd_mux = edge_capture;
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_port     <= OUT_RESET;
      oe_port      <= DIR_RESET;
      irq_mask     <= '0;
      edge_capture <= '0;
      in_prev      <= '0;
      readdata     <= '0;
      irq          <= 1'b0;
    end else begin
      if (wr_en) begin
        case (address)
          ADDR_DATA: out_port <= writedata;
          ADDR_DIR:  oe_port  <= writedata;
          ADDR_MASK: irq_mask <= writedata;
          ADDR_SET:  out_port <= out_port | writedata;
          ADDR_CLR:  out_port <= out_port & ~writedata;
          default:   ;
        endcase
      end
      // A new edge in the same cycle as its clear keeps the bit set.
      edge_capture <= (edge_capture & ~clear_mask) | edge_hit;
      irq          <= |(edge_capture & irq_mask);
      in_prev      <= in_sync;
      if (rd_en) begin
        readdata <= rd_mux;
      end
    end
  end

endmodule
